// File: rtl/seq_adder_if.sv
// Operand/result handshake between the control sequencer and the digit-serial adder.
interface seq_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             abort;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, abort, sub, cin, A, B,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, abort, sub, cin, A, B,
                  output busy, done, sum, cout, ovf);
endinterface

// File: rtl/seq_adder.sv
// Digit-serial add/subtract: WIDTH-bit result built DIGIT bits per RUN cycle, LSB first,
// with start/busy/done handshake and synchronous abort.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic       clk,
  input  logic       NRST,
  seq_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DIGIT:0]   dsum;
  logic             c_msb;

  // One ripple digit; on the last digit, bit DIGIT-1 of the digit is bit WIDTH-1 of the word
  assign dsum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign c_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.abort) state_d = S_IDLE;
        else begin
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          ps_d    = WIDTH'({dsum[DIGIT-1:0], ps_q} >> DIGIT);
          carry_d = dsum[DIGIT];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            sum_d   = ps_d;
            cout_d  = dsum[DIGIT];
            ovf_d   = c_msb ^ dsum[DIGIT];
          end
        end
      end
      S_DONE: begin
        if (bus.abort)      state_d = S_IDLE;
        else if (bus.start) state_d = S_RUN;
        else                state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Operand capture, shared by IDLE and back-to-back DONE starts
    if (state_q != S_RUN && state_d == S_RUN) begin
      a_d     = bus.A;
      b_d     = bus.sub ? ~bus.B : bus.B;
      carry_d = bus.sub | bus.cin;
      cnt_d   = '0;
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: directed handshake scenarios on an 8/2 instance plus a random
// parameter sweep, all checked against an arithmetic reference model.
module tb_seq_adder;
  localparam int W    = 8;
  localparam int D    = 2;
  localparam int NLAT = W / D + 1;

  logic clk;
  logic nrst;
  int   total = 0;
  int   bad   = 0;
  bit   sweep_go = 1'b0;
  int   sweep_fin = 0;

  seq_adder_if #(.WIDTH(W)) bif ();
  seq_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .NRST(nrst), .bus(bif.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Whole-word arithmetic: sum modulo 2^w, unsigned carry/no-borrow, sign-rule overflow
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin,
                       output logic [15:0] s, output logic co, output logic ov);
    longint m, r;
    logic   sa, sb, ss;
    m = longint'(1) << w;
    if (sub) begin
      r  = longint'(a) - longint'(b);
      co = (a >= b);
    end else begin
      r  = longint'(a) + longint'(b) + longint'(cin);
      co = (r >= m);
    end
    s  = 16'(r & (m - 1));
    sa = a[w-1];
    sb = b[w-1];
    ss = s[w-1];
    ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
  endtask

  // Called at a negedge; lat counts edges from the start-sampling edge to the done cycle
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic cin, output int lat);
    bif.A = a; bif.B = b; bif.sub = sub; bif.cin = cin; bif.start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      bif.start = 1'b0;
      if (bif.done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({bif.busy, bif.done, bif.sum, bif.cout, bif.ovf} !== '0) begin
      bad++; $display("FAIL reset_state got=%b required=0", {bif.busy, bif.done, bif.sum, bif.cout, bif.ovf});
    end
    nrst = 1'b1;
  endtask

  task automatic test_add;
    logic [7:0]  ta[2], tb[2];
    logic        tc[2];
    logic [15:0] es;
    logic        eco, eov;
    int          lat;
    ta = '{8'h5A, 8'hFF}; tb = '{8'h3C, 8'h01}; tc = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb[i], 1'b0, tc[i], lat);
      model(8, {8'h0, ta[i]}, {8'h0, tb[i]}, 1'b0, tc[i], es, eco, eov);
      total++;
      if (lat !== NLAT) begin bad++; $display("FAIL add%0d_latency got=%0d required=%0d", i, lat, NLAT); end
      total++;
      if ({bif.ovf, bif.cout, bif.sum} !== {eov, eco, es[7:0]}) begin
        bad++; $display("FAIL add%0d_result got=%h required=%h", i, {bif.ovf, bif.cout, bif.sum}, {eov, eco, es[7:0]});
      end
    end
  endtask

  task automatic test_sub;
    logic [7:0]  ta[3], tb[3];
    logic        tc[3];
    logic [15:0] es;
    logic        eco, eov;
    int          lat;
    ta = '{8'h10, 8'h80, 8'h10}; tb = '{8'h20, 8'h01, 8'h20}; tc = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b1, tc[i], lat);
      model(8, {8'h0, ta[i]}, {8'h0, tb[i]}, 1'b1, tc[i], es, eco, eov);
      total++;
      if (lat !== NLAT) begin bad++; $display("FAIL sub%0d_latency got=%0d required=%0d", i, lat, NLAT); end
      total++;
      if ({bif.ovf, bif.cout, bif.sum} !== {eov, eco, es[7:0]}) begin
        bad++; $display("FAIL sub%0d_result got=%h required=%h", i, {bif.ovf, bif.cout, bif.sum}, {eov, eco, es[7:0]});
      end
    end
  endtask

  task automatic test_ignored_start;
    int          lat, ndone;
    logic [15:0] es;
    logic        eco, eov;
    bif.A = 8'h21; bif.B = 8'h13; bif.sub = 1'b0; bif.cin = 1'b0; bif.start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      bif.start = (c == 2);
      if (c == 2) begin bif.A = 8'hF0; bif.B = 8'h0F; bif.sub = 1'b1; end
      if (bif.done) begin lat = c; break; end
    end
    model(8, 16'h21, 16'h13, 1'b0, 1'b0, es, eco, eov);
    total++;
    if (lat !== NLAT) begin bad++; $display("FAIL ignstart_latency got=%0d required=%0d", lat, NLAT); end
    total++;
    if ({bif.ovf, bif.cout, bif.sum} !== {eov, eco, es[7:0]}) begin
      bad++; $display("FAIL ignstart_result got=%h required=%h", {bif.ovf, bif.cout, bif.sum}, {eov, eco, es[7:0]});
    end
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (bif.done) ndone++;
    end
    total++;
    if (ndone !== 0 || bif.busy !== 1'b0) begin
      bad++; $display("FAIL ignstart_no_queue dones=%0d busy=%b required 0/0", ndone, bif.busy);
    end
  endtask

  task automatic test_abort;
    int          lat, ndone;
    logic [15:0] es;
    logic        eco, eov;
    logic [9:0]  held;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
    held = {bif.ovf, bif.cout, bif.sum};
    total++;
    if (held !== 10'h296) begin bad++; $display("FAIL abort_setup got=%h required=296", held); end
    bif.A = 8'h01; bif.B = 8'h01; bif.sub = 1'b0; bif.start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      bif.start = 1'b0;
      bif.abort = (c == 2);
      if (c == 3) begin
        total++;
        if (bif.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b required=0", bif.busy); end
      end
      if (bif.done) ndone++;
    end
    total++;
    if (ndone !== 0 || {bif.ovf, bif.cout, bif.sum} !== held) begin
      bad++; $display("FAIL abort_hold dones=%0d got=%h required=0/%h", ndone, {bif.ovf, bif.cout, bif.sum}, held);
    end
    bif.A = 8'h05; bif.B = 8'h03; bif.start = 1'b1; bif.abort = 1'b1;
    @(posedge clk); @(negedge clk);
    bif.start = 1'b0; bif.abort = 1'b0;
    total++;
    if (bif.busy !== 1'b1) begin bad++; $display("FAIL abort_start_idle busy=%b required=1", bif.busy); end
    lat = -1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (bif.done) begin lat = c; break; end
    end
    model(8, 16'h05, 16'h03, 1'b0, 1'b0, es, eco, eov);
    total++;
    if (lat !== NLAT || {bif.ovf, bif.cout, bif.sum} !== {eov, eco, es[7:0]}) begin
      bad++; $display("FAIL abort_start_result lat=%0d got=%h required=%0d/%h", lat, {bif.ovf, bif.cout, bif.sum}, NLAT, {eov, eco, es[7:0]});
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e1, e2;
    logic        c1, o1, c2, o2;
    int          t1, t2;
    model(8, 16'h33, 16'h44, 1'b0, 1'b0, e1, c1, o1);
    model(8, 16'hC8, 16'h37, 1'b1, 1'b0, e2, c2, o2);
    bif.A = 8'h33; bif.B = 8'h44; bif.sub = 1'b0; bif.cin = 1'b0; bif.start = 1'b1;
    t1 = -1; t2 = -1;
    for (int c = 1; c <= 40 && t2 < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (bif.done) begin
        if (t1 < 0) begin
          t1 = c;
          total++;
          if ({bif.ovf, bif.cout, bif.sum} !== {o1, c1, e1[7:0]}) begin
            bad++; $display("FAIL b2b_first got=%h required=%h", {bif.ovf, bif.cout, bif.sum}, {o1, c1, e1[7:0]});
          end
          bif.A = 8'hC8; bif.B = 8'h37; bif.sub = 1'b1;
        end else begin
          t2 = c;
          bif.start = 1'b0;
          total++;
          if ({bif.ovf, bif.cout, bif.sum} !== {o2, c2, e2[7:0]}) begin
            bad++; $display("FAIL b2b_second got=%h required=%h", {bif.ovf, bif.cout, bif.sum}, {o2, c2, e2[7:0]});
          end
        end
      end
    end
    bif.start = 1'b0;
    total++;
    if (t1 !== NLAT || t2 !== 2 * NLAT) begin
      bad++; $display("FAIL b2b_spacing t1=%0d t2=%0d required=%0d/%0d", t1, t2, NLAT, 2 * NLAT);
    end
  endtask

  task automatic test_reset_mid_run;
    int          lat;
    logic [15:0] es;
    logic        eco, eov;
    @(negedge clk);
    bif.A = 8'h5A; bif.B = 8'h3C; bif.sub = 1'b0; bif.cin = 1'b0; bif.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bif.start = 1'b0;
    @(posedge clk); @(negedge clk);
    nrst = 1'b0;
    #1;
    total++;
    if ({bif.busy, bif.done, bif.sum, bif.cout, bif.ovf} !== '0) begin
      bad++; $display("FAIL reset_mid_run got=%b required=0", {bif.busy, bif.done, bif.sum, bif.cout, bif.ovf});
    end
    @(negedge clk);
    nrst = 1'b1;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
    model(8, 16'h5A, 16'h3C, 1'b0, 1'b0, es, eco, eov);
    total++;
    if (lat !== NLAT || {bif.ovf, bif.cout, bif.sum} !== {eov, eco, es[7:0]}) begin
      bad++; $display("FAIL reset_recover lat=%0d got=%h required=%0d/%h", lat, {bif.ovf, bif.cout, bif.sum}, NLAT, {eov, eco, es[7:0]});
    end
  endtask

  task automatic test_sweep;
    sweep_go = 1'b1;
    for (int c = 0; c < 4000 && sweep_fin < 4; c++) @(negedge clk);
    total++;
    if (sweep_fin !== 4) begin bad++; $display("FAIL sweep_timeout finished=%0d required=4", sweep_fin); end
  endtask

  // Sweep instances: (8,1) (8,4) (8,8) (16,4)
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int SW = (g == 3) ? 16 : 8;
    localparam int SD = (g == 0) ? 1 : (g == 2) ? 8 : 4;
    localparam int SN = SW / SD;

    seq_adder_if #(.WIDTH(SW)) sif ();
    seq_adder #(.WIDTH(SW), .DIGIT(SD)) u_dut (.clk(clk), .NRST(nrst), .bus(sif.slave));

    initial begin
      logic [15:0] ra, rb, es;
      logic        rs, rc, eco, eov;
      int          lat;
      sif.start = 1'b0; sif.abort = 1'b0; sif.sub = 1'b0; sif.cin = 1'b0;
      sif.A = '0; sif.B = '0;
      wait (sweep_go);
      for (int i = 0; i < 24; i++) begin
        ra = 16'($urandom) >> (16 - SW);
        rb = 16'($urandom) >> (16 - SW);
        rs = 1'($urandom);
        rc = 1'($urandom);
        @(negedge clk);
        sif.A = ra[SW-1:0]; sif.B = rb[SW-1:0]; sif.sub = rs; sif.cin = rc; sif.start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
          @(posedge clk); @(negedge clk);
          sif.start = 1'b0;
          if (sif.done) begin lat = c; break; end
        end
        model(SW, ra, rb, rs, rc, es, eco, eov);
        total++;
        if (lat != SN + 1) begin
          bad++; $display("FAIL sweep_w%0d_d%0d_latency got=%0d required=%0d", SW, SD, lat, SN + 1);
        end
        total++;
        if ({sif.ovf, sif.cout, sif.sum} !== {eov, eco, es[SW-1:0]}) begin
          bad++; $display("FAIL sweep_w%0d_d%0d_result a=%h b=%h sub=%b cin=%b got=%h required=%h",
                          SW, SD, ra, rb, rs, rc, {sif.ovf, sif.cout, sif.sum}, {eov, eco, es[SW-1:0]});
        end
      end
      sweep_fin++;
    end
  end

  initial begin
    nrst = 1'b0;
    bif.start = 1'b0; bif.abort = 1'b0; bif.sub = 1'b0; bif.cin = 1'b0;
    bif.A = '0; bif.B = '0;
    test_reset;
    test_add;
    test_sub;
    test_ignored_start;
    test_abort;
    test_back_to_back;
    test_reset_mid_run;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
